// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register controller: access size
// encodings, controller FSM states and lane/extension width constants.
package mdr_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10,
        FAULT   = 2'b11
    } state_e;

    localparam int BYTE_BITS = 8;
    localparam int HALF_BITS = 16;
    localparam int WORD_BITS = 32;

endpackage

// File: rtl/mdr_if.sv
// Memory-side bus between the MDR controller (master) and the memory (slave).
interface mdr_if #(
    parameter int REG_SIZE = 32
);
    logic                  m_req;
    logic                  m_we;
    logic                  m_ack;
    logic [REG_SIZE-1:0]   m_data_in;
    logic [REG_SIZE-1:0]   m_data_out;
    logic [REG_SIZE/8-1:0] m_be;

    modport master (
        output m_req, m_we, m_data_out, m_be,
        input  m_ack, m_data_in
    );

    modport slave (
        input  m_req, m_we, m_data_out, m_be,
        output m_ack, m_data_in
    );
endinterface

// File: rtl/mdr_extend.sv
// Read-path lane selection: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to the full register width.
module mdr_extend
    import mdr_pkg::*;
#(
    parameter int REG_SIZE = 32,
    localparam int ADDR_W  = $clog2(REG_SIZE/8)
) (
    input  logic [REG_SIZE-1:0] data,
    input  size_e               size,
    input  logic [ADDR_W-1:0]   offset,
    input  logic                sign_ext,
    output logic [REG_SIZE-1:0] result
);

    logic [REG_SIZE-1:0] shifted;
    logic [REG_SIZE-1:0] mask;
    logic                msb;

    // Right-justify the addressed lane, keep its width via mask, fill the rest with the extension bit
    always_comb begin
        shifted = data >> {offset, 3'b000};
        mask    = '1;
        msb     = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask = REG_SIZE'({BYTE_BITS{1'b1}});
                msb  = shifted[BYTE_BITS-1];
            end
            SZ_HALF: begin
                mask = REG_SIZE'({HALF_BITS{1'b1}});
                msb  = shifted[HALF_BITS-1];
            end
            SZ_WORD: begin
                mask = REG_SIZE'({WORD_BITS{1'b1}});
                msb  = shifted[WORD_BITS-1];
            end
            default: begin
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        result = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mdr_ctrl.sv
// Memory data register controller: loads the MDR from the internal bus and
// runs byte/half/word/dword reads and writes over the memory bus interface.
// Optional feature: define MDR_TIMEOUT_EN to abort wait states that see no
// m_ack within TIMEOUT cycles.
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int REG_SIZE = 32,
    parameter int TIMEOUT  = 15,
    localparam int ADDR_W  = $clog2(REG_SIZE/8),
    localparam int BYTES   = REG_SIZE/8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mdr_in,
    input  logic [REG_SIZE-1:0] bus_mux_out,
    input  logic                rd_start,
    input  logic                wr_start,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [ADDR_W-1:0]   addr_lo,
    mdr_if.master               bus,
    output logic [REG_SIZE-1:0] mdr_output,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e              state;
    logic [REG_SIZE-1:0] mdr_q;
    logic                m_req_q;
    logic                m_we_q;
    logic [BYTES-1:0]    m_be_q;
    logic [REG_SIZE-1:0] m_data_out_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    size_e               cap_size;
    logic [ADDR_W-1:0]   cap_off;
    logic                cap_sign;

    size_e               size_in;
    logic                start_misaligned;
    logic [BYTES-1:0]    start_be;
    logic [REG_SIZE-1:0] start_wdata;
    logic [REG_SIZE-1:0] rd_data;
    int                  rep_mask;

    assign size_in = size_e'(size);

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;
    assign tmo_next = tmo_cnt + 1'b1;
`else
    // TIMEOUT has no effect in this build: wait states last until m_ack.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // Decode the requested access: alignment check, byte enables and replicated write data
    always_comb begin
        start_misaligned = 1'b0;
        start_be         = '0;
        rep_mask         = BYTES - 1;
        case (size_in)
            SZ_BYTE: begin
                start_misaligned = 1'b0;
                start_be         = BYTES'(1) << addr_lo;
                rep_mask         = 0;
            end
            SZ_HALF: begin
                start_misaligned = addr_lo[0];
                start_be         = BYTES'(2'b11) << addr_lo;
                rep_mask         = 1;
            end
            SZ_WORD: begin
                start_misaligned = (addr_lo & ADDR_W'(3)) != '0;
                start_be         = BYTES'(4'hF) << addr_lo;
                rep_mask         = 3;
            end
            default: begin
                start_misaligned = (REG_SIZE == 32) ? 1'b1 : (addr_lo != '0);
                start_be         = '1;
                rep_mask         = BYTES - 1;
            end
        endcase
        start_wdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            start_wdata[8*i +: 8] = mdr_q[8*(i & rep_mask) +: 8];
        end
    end

    mdr_extend #(.REG_SIZE(REG_SIZE)) u_extend (
        .data     (bus.m_data_in),
        .size     (cap_size),
        .offset   (cap_off),
        .sign_ext (cap_sign),
        .result   (rd_data)
    );

    // Controller FSM: owns the MDR, the registered bus outputs and the status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mdr_q        <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_be_q       <= '0;
            m_data_out_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cap_size     <= SZ_BYTE;
            cap_off      <= '0;
            cap_sign     <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start || wr_start) begin
                        if (start_misaligned) begin
                            state  <= FAULT;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state        <= rd_start ? RD_WAIT : WR_WAIT;
                            m_req_q      <= 1'b1;
                            m_we_q       <= !rd_start;
                            busy_q       <= 1'b1;
                            m_be_q       <= start_be;
                            m_data_out_q <= rd_start ? '0 : start_wdata;
                            cap_size     <= size_in;
                            cap_off      <= addr_lo;
                            cap_sign     <= sign_ext;
`ifdef MDR_TIMEOUT_EN
                            tmo_cnt      <= '0;
`endif
                        end
                    end else if (mdr_in) begin
                        mdr_q <= bus_mux_out;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (bus.m_ack) begin
                        if (state == RD_WAIT) begin
                            mdr_q <= rd_data;
                        end
                        state        <= IDLE;
                        m_req_q      <= 1'b0;
                        m_we_q       <= 1'b0;
                        m_be_q       <= '0;
                        m_data_out_q <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                    end else if (tmo_next == CNT_W'(TIMEOUT)) begin
                        tmo_cnt      <= tmo_next;
                        state        <= IDLE;
                        m_req_q      <= 1'b0;
                        m_we_q       <= 1'b0;
                        m_be_q       <= '0;
                        m_data_out_q <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        err_q        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_next;
`endif
                    end
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_req      = m_req_q;
    assign bus.m_we       = m_we_q;
    assign bus.m_be       = m_be_q;
    assign bus.m_data_out = m_data_out_q;
    assign mdr_output     = mdr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
